sram_rw_scheduler: RTL and testbench

SRAM_RW_SCHEDULER -- requirements
Module: sram_rw_scheduler

---
 rtl/sram_rw_scheduler_pkg.sv | 18 +
 rtl/sram_rw_scheduler_ring_ptr.sv | 29 ++
 rtl/sram_rw_scheduler.sv | 110 +++++++++++
 tb/tb_sram_rw_scheduler.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sram_rw_scheduler_pkg.sv
// rtl/sram_rw_scheduler_pkg.sv - shared state encoding and default constants for the SRAM read/write scheduler
package sram_rw_scheduler_pkg;

  typedef enum logic [1:0] {
    CAL_WAIT = 2'd0,
    IDLE     = 2'd1,
    WRITE    = 2'd2,
    READ     = 2'd3
  } sched_state_e;

  localparam int DEF_ADDR_WIDTH = 19;
  localparam int DEF_BURST_LEN  = 8;
  localparam int DEF_WR_URGENT  = 64;

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

endpackage

// File: rtl/sram_rw_scheduler_ring_ptr.sv
// rtl/sram_rw_scheduler_ring_ptr.sv - write/read pointers and occupancy of the SRAM ring buffer
module sram_ring_ptr #(
  parameter int ADDR_WIDTH = 19
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_acc,
  input  logic                  rd_acc,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   used
);

  // Only one command is accepted per cycle, so the two updates never coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + 1'b1;
      used   <= used + 1'b1;
    end else if (rd_acc) begin
      rd_ptr <= rd_ptr + 1'b1;
      used   <= used - 1'b1;
    end
  end

endmodule

// File: rtl/sram_rw_scheduler.sv
// rtl/sram_rw_scheduler.sv - arbitrates bursts of SRAM writes (input FIFO -> ring) and reads (ring -> output)
module sram_rw_scheduler
  import sram_rw_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BURST_LEN  = DEF_BURST_LEN,
  parameter int WR_URGENT  = DEF_WR_URGENT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cal_done,
  input  logic                  in_fifo_empty,
  input  logic [31:0]           in_fifo_cnt,
  output logic                  in_fifo_rden,
  input  logic [15:0]           out_fifo_room,
  output logic                  sram_cmd_valid,
  input  logic                  sram_cmd_ready,
  output logic                  sram_cmd_wr,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [ADDR_WIDTH:0]   sram_used,
  output logic                  rd_issued
);

  localparam int CW = $clog2(BURST_LEN + 1);
  localparam logic [ADDR_WIDTH:0] CAP      = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] CAP_M1   = {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] ONE      = (ADDR_WIDTH+1)'(1);
  localparam logic [15:0]         ROOM_MIN = 16'(BURST_LEN);
  localparam logic [31:0]         URGENT   = 32'(WR_URGENT);
  localparam logic [CW-1:0]       BURST_LAST = CW'(BURST_LEN - 1);

  sched_state_e          state;
  logic [CW-1:0]         burst_cnt;
  logic                  last_grant;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  accepted;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  wr_elig;
  logic                  rd_elig;
  logic                  pick_wr;
  logic                  wr_more;
  logic                  rd_more;

  assign accepted     = sram_cmd_valid && sram_cmd_ready;
  assign wr_acc       = accepted && sram_cmd_wr;
  assign rd_acc       = accepted && !sram_cmd_wr;
  assign in_fifo_rden = wr_acc;
  assign rd_issued    = rd_acc;

  assign wr_elig = !in_fifo_empty && (sram_used < CAP);
  assign rd_elig = (sram_used != '0) && (out_fifo_room >= ROOM_MIN);
  assign pick_wr = wr_elig && (!rd_elig || (in_fifo_cnt >= URGENT) || (last_grant == GRANT_RD));

  // Eligibility as it will stand once the command being accepted now has taken effect.
  assign wr_more = (in_fifo_cnt > 32'd1) && (sram_used < CAP_M1);
  assign rd_more = (sram_used > ONE);

  sram_ring_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_ring_ptr (
    .clk    (clk),
    .reset  (reset),
    .wr_acc (wr_acc),
    .rd_acc (rd_acc),
    .wr_ptr (wr_ptr),
    .rd_ptr (rd_ptr),
    .used   (sram_used)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CAL_WAIT;
      burst_cnt      <= '0;
      last_grant     <= GRANT_RD;
      sram_cmd_valid <= 1'b0;
      sram_cmd_wr    <= 1'b0;
      sram_addr      <= '0;
    end else begin
      case (state)
        CAL_WAIT: if (cal_done) state <= IDLE;
        IDLE: begin
          if (!cal_done) begin
            state <= CAL_WAIT;
          end else if (wr_elig || rd_elig) begin
            state          <= pick_wr ? WRITE : READ;
            sram_cmd_valid <= 1'b1;
            sram_cmd_wr    <= pick_wr;
            sram_addr      <= pick_wr ? wr_ptr : rd_ptr;
            last_grant     <= pick_wr;
            burst_cnt      <= '0;
          end
        end
        WRITE, READ: begin
          // The address register tracks the active pointer, so +1 follows it through the wrap.
          if (accepted) begin
            burst_cnt <= burst_cnt + 1'b1;
            if (!cal_done || (burst_cnt == BURST_LAST) || !(sram_cmd_wr ? wr_more : rd_more)) begin
              sram_cmd_valid <= 1'b0;
              state          <= cal_done ? IDLE : CAL_WAIT;
            end else begin
              sram_addr <= sram_addr + 1'b1;
            end
          end
        end
        default: state <= CAL_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_rw_scheduler.sv
// tb/tb_sram_rw_scheduler.sv - self-checking bench for sram_rw_scheduler against a count-based reference model
module tb_sram_rw_scheduler;

  localparam int AW  = 5;
  localparam int BL  = 8;
  localparam int WU  = 64;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          cal_done;
  logic          in_fifo_empty;
  logic [31:0]   in_fifo_cnt;
  logic          in_fifo_rden;
  logic [15:0]   out_fifo_room;
  logic          sram_cmd_valid;
  logic          sram_cmd_ready;
  logic          sram_cmd_wr;
  logic [AW-1:0] sram_addr;
  logic [AW:0]   sram_used;
  logic          rd_issued;

  int pushed = 0;
  int pops = 0;
  assign in_fifo_cnt   = 32'(pushed - pops);
  assign in_fifo_empty = (pushed == pops);

  always #5 clk = ~clk;

  sram_rw_scheduler #(.ADDR_WIDTH(AW), .BURST_LEN(BL), .WR_URGENT(WU)) dut (
    .clk            (clk),
    .reset          (reset),
    .cal_done       (cal_done),
    .in_fifo_empty  (in_fifo_empty),
    .in_fifo_cnt    (in_fifo_cnt),
    .in_fifo_rden   (in_fifo_rden),
    .out_fifo_room  (out_fifo_room),
    .sram_cmd_valid (sram_cmd_valid),
    .sram_cmd_ready (sram_cmd_ready),
    .sram_cmd_wr    (sram_cmd_wr),
    .sram_addr      (sram_addr),
    .sram_used      (sram_used),
    .rd_issued      (rd_issued)
  );

  // Reference model: total writes/reads since reset give occupancy and both addresses.
  int m_phase = 0;  // 0 waiting for calibration, 1 choosing a side, 2 issuing a burst
  int m_wr = 0;
  int m_rd = 0;
  int m_burst = 0;
  int m_addr = 0;
  int m_used;
  bit m_last_w = 0;
  bit m_valid = 0;
  bit m_is_wr = 0;
  bit m_weli, m_reli, m_pick_w, m_more;

  always @(posedge clk) begin
    m_used = m_wr - m_rd;
    if (reset) begin
      m_phase = 0; m_wr = 0; m_rd = 0; m_burst = 0; m_addr = 0;
      m_last_w = 0; m_valid = 0; m_is_wr = 0;
    end else if (m_phase == 0) begin
      if (cal_done) m_phase = 1;
    end else if (m_phase == 1) begin
      if (!cal_done) begin
        m_phase = 0;
      end else begin
        m_weli = (in_fifo_cnt != 0) && (m_used < CAP);
        m_reli = (m_used > 0) && (out_fifo_room >= BL);
        if (m_weli || m_reli) begin
          m_pick_w = m_weli && (!m_reli || in_fifo_cnt >= WU || !m_last_w);
          m_last_w = m_pick_w;
          m_is_wr  = m_pick_w;
          m_valid  = 1;
          m_burst  = 0;
          m_addr   = m_pick_w ? (m_wr % CAP) : (m_rd % CAP);
          m_phase  = 2;
        end
      end
    end else if (sram_cmd_ready) begin
      m_burst++;
      if (m_is_wr) begin
        m_wr++;
        pops <= pops + 1;
        m_more = (in_fifo_cnt > 1) && (m_wr - m_rd < CAP);
      end else begin
        m_rd++;
        m_more = (m_wr - m_rd > 0);
      end
      if (m_burst == BL || !m_more || !cal_done) begin
        m_valid = 0;
        m_phase = cal_done ? 1 : 0;
      end else begin
        m_addr = m_is_wr ? (m_wr % CAP) : (m_rd % CAP);
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int rden_seen = 0;
  int n;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    check("valid", 64'(sram_cmd_valid), 64'(m_valid));
    check("used", 64'(sram_used), 64'(m_wr - m_rd));
    check("rden", 64'(in_fifo_rden), 64'(m_valid && m_is_wr && sram_cmd_ready));
    check("rd_issued", 64'(rd_issued), 64'(m_valid && !m_is_wr && sram_cmd_ready));
    if (m_valid) begin
      check("wr", 64'(sram_cmd_wr), 64'(m_is_wr));
      check("addr", 64'(sram_addr), 64'(m_addr));
    end
    if (in_fifo_rden) rden_seen++;
  endtask

  task automatic wait_valid(input string tag);
    n = 0;
    while (n < 10 && !sram_cmd_valid) begin cyc(); n++; end
    check(tag, 64'(sram_cmd_valid), 64'd1);
  endtask

  initial begin
    reset = 1'b1; cal_done = 1'b0; sram_cmd_ready = 1'b1; out_fifo_room = 16'd0;
    repeat (3) cyc();
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_wr", 64'(sram_cmd_wr), 64'd0);
    check("rst_used", 64'(sram_used), 64'd0);

    // Calibration hold with data waiting, then two cycles to first command.
    reset = 1'b0; pushed += 12;
    repeat (20) cyc();
    check("cal_hold_valid", 64'(sram_cmd_valid), 64'd0);
    cal_done = 1'b1; rden_seen = 0; n = 0;
    while (n < 6 && !sram_cmd_valid) begin cyc(); n++; end
    check("cal_latency", 64'(n), 64'd2);

    // 12 words: bursts of 8 then 4.
    repeat (30) cyc();
    check("burst12_rden", 64'(rden_seen), 64'd12);
    check("burst12_used", 64'(sram_used), 64'd12);

    // Grow to 20, then both sides eligible: alternating grants.
    pushed += 8;
    repeat (20) cyc();
    check("used20", 64'(sram_used), 64'd20);
    pushed += 10; out_fifo_room = 16'd16;
    repeat (60) cyc();

    // Urgent write backlog fills the ring; writes withheld at full.
    out_fifo_room = 16'd0; pushed += 64;
    repeat (60) cyc();
    check("full_used", 64'(sram_used), 64'd32);
    check("full_no_cmd", 64'(sram_cmd_valid), 64'd0);

    // Reads resume on a full ring; stall mid-burst for five cycles.
    out_fifo_room = 16'd16;
    repeat (3) cyc();
    sram_cmd_ready = 1'b0;
    repeat (5) cyc();
    sram_cmd_ready = 1'b1;
    repeat (40) cyc();

    // Calibration lost while a command is pending.
    sram_cmd_ready = 1'b0;
    wait_valid("caldrop_grant");
    cal_done = 1'b0;
    repeat (3) cyc();
    check("caldrop_hold", 64'(sram_cmd_valid), 64'd1);
    sram_cmd_ready = 1'b1;
    cyc();
    check("caldrop_release", 64'(sram_cmd_valid), 64'd0);
    repeat (4) cyc();
    cal_done = 1'b1;

    // Reset in the middle of a burst.
    wait_valid("rstmid_grant");
    cyc();
    reset = 1'b1;
    cyc();
    check("rstmid_valid", 64'(sram_cmd_valid), 64'd0);
    check("rstmid_used", 64'(sram_used), 64'd0);
    check("rstmid_addr", 64'(sram_addr), 64'd0);
    check("rstmid_rden", 64'(in_fifo_rden), 64'd0);
    reset = 1'b0;

    // Randomized traffic; ring wraps many times.
    for (int i = 0; i < 4000; i++) begin
      sram_cmd_ready = ($urandom_range(0, 9) < 7);
      out_fifo_room  = 16'($urandom_range(0, 16));
      cal_done       = ($urandom_range(0, 99) >= 3);
      reset          = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 9) < 4) pushed += $urandom_range(1, 4);
      if (in_fifo_cnt > 200) pushed = pops;
      cyc();
    end
    check("final_wraps", 64'(m_rd > CAP), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
